// File: rtl/parking_pkg.sv
// Shared types and default sizing for the parking-lot gate sequencer.
// Constants are the defaults picked up by gate_ctrl's parameters.
package parking_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OPEN = 2'd1,
      PASS = 2'd2
   } gate_state_t;

   localparam int MAX_CARS  = 3;
   localparam int LAST_HOUR = 7;

   // A gate asks for its pulse only once the car has fully cleared.
   function automatic logic is_req(input gate_state_t st);
      return st == PASS;
   endfunction

endpackage

// File: rtl/gate_fsm.sv
// One gate's IDLE -> OPEN -> PASS sequencer; the top instantiates it per gate
// and arbitrates the PASS requests so pulses never collide.
module gate_fsm
   import parking_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        sensor_i,
   input  logic        permit_i,
   input  logic        grant_i,
   output logic        req_o,
   output logic        open_o,
   output gate_state_t state_o
);

   gate_state_t state_q;
   logic        open_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         open_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // Permit is checked only here, so a car already inside the
               // gate finishes even if the lot fills or the day ends.
               if (sensor_i && permit_i) begin
                  state_q <= OPEN;
                  open_q  <= 1'b1;
               end
            end
            OPEN: begin
               if (!sensor_i) state_q <= PASS;
            end
            PASS: begin
               if (grant_i) begin
                  state_q <= IDLE;
                  open_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               open_q  <= 1'b0;
            end
         endcase
      end
   end

   assign req_o   = is_req(state_q);
   assign open_o  = open_q;
   assign state_o = state_q;

endmodule

// File: rtl/gate_ctrl.sv
// Gate sequencing ahead of the parking datapath: synchronizes sensors and the
// hour key, runs both gate FSMs, arbitrates their pulses, and tracks the hour.
module gate_ctrl #(
   parameter int MAX_CARS  = parking_pkg::MAX_CARS,
   parameter int LAST_HOUR = parking_pkg::LAST_HOUR
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       entry_sensor,
   input  logic       exit_sensor,
   input  logic       hour_key,
   input  logic [1:0] currCar,
   output logic       entrance_gate,
   output logic       exit_gate,
   output logic       entry_open,
   output logic       exit_open,
   output logic       full,
   output logic [2:0] hour,
   output logic       day_done
);

   import parking_pkg::*;

   // Bit order in the synchronizer: {hour_key, exit, entry}.
   logic [2:0]  sync1_q, sync2_q;
   logic        key_prev_q;
   logic [2:0]  hour_q;
   logic        day_done_q;
   logic        entr_pulse_q, exit_pulse_q;

   logic        entry_s, exit_s, key_s, key_rise;
   logic        entry_permit, exit_permit;
   logic        entry_req, exit_req;
   logic        entry_grant, exit_grant;
   gate_state_t entry_state, exit_state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= {hour_key, exit_sensor, entry_sensor};
         sync2_q <= sync1_q;
      end
   end

   assign entry_s  = sync2_q[0];
   assign exit_s   = sync2_q[1];
   assign key_s    = sync2_q[2];
   assign key_rise = key_s && !key_prev_q;

   assign full         = (currCar == 2'(MAX_CARS));
   assign entry_permit = !full && !day_done_q;
   assign exit_permit  = (currCar != 2'd0);

   gate_fsm u_entry (
      .clk      (clk),
      .reset    (reset),
      .sensor_i (entry_s),
      .permit_i (entry_permit),
      .grant_i  (entry_grant),
      .req_o    (entry_req),
      .open_o   (entry_open),
      .state_o  (entry_state)
   );

   gate_fsm u_exit (
      .clk      (clk),
      .reset    (reset),
      .sensor_i (exit_s),
      .permit_i (exit_permit),
      .grant_i  (exit_grant),
      .req_o    (exit_req),
      .open_o   (exit_open),
      .state_o  (exit_state)
   );

   // Exit wins a tie; the entry request simply waits one more cycle in PASS.
   assign exit_grant  = exit_req;
   assign entry_grant = entry_req && !exit_req;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         entr_pulse_q <= 1'b0;
         exit_pulse_q <= 1'b0;
      end else begin
         entr_pulse_q <= entry_grant;
         exit_pulse_q <= exit_grant;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_prev_q <= 1'b0;
         hour_q     <= '0;
         day_done_q <= 1'b0;
      end else begin
         key_prev_q <= key_s;
         if (key_rise) begin
            if (hour_q < 3'(LAST_HOUR)) hour_q <= hour_q + 3'd1;
            else                        day_done_q <= 1'b1;
         end
      end
   end

   assign entrance_gate = entr_pulse_q;
   assign exit_gate     = exit_pulse_q;
   assign hour          = hour_q;
   assign day_done      = day_done_q;

   a_one_pulse: assert property (@(posedge clk) disable iff (reset)
      !(entr_pulse_q && exit_pulse_q));
   a_entry_hold: assert property (@(posedge clk) disable iff (reset)
      (entry_state == IDLE && !entry_permit) |=> entry_state == IDLE);
   a_exit_hold: assert property (@(posedge clk) disable iff (reset)
      (exit_state == IDLE && !exit_permit) |=> exit_state == IDLE);

endmodule

// File: tb/tb_gate_ctrl.sv
// Directed-vector bench for gate_ctrl with hand-computed expectations.
module tb_gate_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       entry_sensor, exit_sensor, hour_key;
   logic [1:0] currCar;
   logic       entrance_gate, exit_gate, entry_open, exit_open, full, day_done;
   logic [2:0] hour;

   int errs   = 0;
   int checks = 0;
   logic seen;

   gate_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .entry_sensor  (entry_sensor),
      .exit_sensor   (exit_sensor),
      .hour_key      (hour_key),
      .currCar       (currCar),
      .entrance_gate (entrance_gate),
      .exit_gate     (exit_gate),
      .entry_open    (entry_open),
      .exit_open     (exit_open),
      .full          (full),
      .hour          (hour),
      .day_done      (day_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, landing 1 time unit after the last edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset = 1'b1; entry_sensor = 0; exit_sensor = 0; hour_key = 0; currCar = 2'd0;
      #12;
      chk("rst_entry_open", entry_open, 0);
      chk("rst_exit_open", exit_open, 0);
      chk("rst_entr_gate", entrance_gate, 0);
      chk("rst_exit_gate", exit_gate, 0);
      chk("rst_hour", hour, 0);
      chk("rst_day_done", day_done, 0);
      chk("rst_full", full, 0);
      reset = 1'b0;
      step(2);

      // Basic entry: opens two edges after the first sampling edge.
      entry_sensor = 1;
      step(2);
      chk("ent_open_k1", entry_open, 0);
      step(1);
      chk("ent_open_k2", entry_open, 1);
      step(1);
      entry_sensor = 0;
      step(3);
      chk("ent_pass_open", entry_open, 1);
      chk("ent_gate_m2", entrance_gate, 0);
      step(1);
      chk("ent_gate_m3", entrance_gate, 1);
      chk("ent_exit_m3", exit_gate, 0);
      step(1);
      chk("ent_gate_m4", entrance_gate, 0);
      chk("ent_closed", entry_open, 0);

      // Full lot holds the gate shut until occupancy drops.
      currCar = 2'd3;
      entry_sensor = 1;
      #1;
      chk("full_comb", full, 1);
      step(5);
      chk("full_no_open", entry_open, 0);
      currCar = 2'd2;
      step(1);
      chk("full_released_open", entry_open, 1);
      entry_sensor = 0;
      step(6);
      chk("full_done_closed", entry_open, 0);

      // Simultaneous clear: exit first, entry one cycle later.
      currCar = 2'd1;
      entry_sensor = 1; exit_sensor = 1;
      step(4);
      chk("sim_entry_open", entry_open, 1);
      chk("sim_exit_open", exit_open, 1);
      entry_sensor = 0; exit_sensor = 0;
      step(3);
      chk("sim_m2_exit", exit_gate, 0);
      chk("sim_m2_entr", entrance_gate, 0);
      step(1);
      chk("sim_m3_exit", exit_gate, 1);
      chk("sim_m3_entr", entrance_gate, 0);
      step(1);
      chk("sim_m4_exit", exit_gate, 0);
      chk("sim_m4_entr", entrance_gate, 1);
      step(1);
      chk("sim_m5_entr", entrance_gate, 0);

      // Empty lot: exit never opens.
      currCar = 2'd0;
      exit_sensor = 1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         seen = seen | exit_gate | exit_open;
      end
      chk("empty_no_exit", seen, 0);
      exit_sensor = 0;
      step(2);

      // Hour key presses, one increment per press even while held.
      for (int i = 1; i <= 7; i++) begin
         hour_key = 1;
         step(2);
         chk("hour_pre", hour, i - 1);
         step(1);
         chk("hour_inc", hour, i);
         step(3);
         chk("hour_held", hour, i);
         hour_key = 0;
         step(3);
      end
      chk("hour_no_done", day_done, 0);
      hour_key = 1;
      step(3);
      chk("hour_sat", hour, 7);
      chk("day_done_set", day_done, 1);
      hour_key = 0;
      step(3);

      // Day over: entry refused, exit still works.
      entry_sensor = 1;
      step(6);
      chk("done_entry_refused", entry_open, 0);
      entry_sensor = 0;
      step(2);
      currCar = 2'd1;
      exit_sensor = 1;
      step(3);
      chk("done_exit_open", exit_open, 1);
      exit_sensor = 0;
      step(3);
      chk("done_exit_m2", exit_gate, 0);
      step(1);
      chk("done_exit_m3", exit_gate, 1);
      step(1);
      chk("done_exit_m4", exit_gate, 0);
      chk("done_sticky", day_done, 1);

      // Asynchronous reset while entry is OPEN aborts the transaction.
      currCar = 2'd0;
      reset = 1; #2; reset = 0;
      step(1);
      entry_sensor = 1;
      step(3);
      chk("ar_open", entry_open, 1);
      #3;
      reset = 1;
      #1;
      chk("ar_entry_open", entry_open, 0);
      chk("ar_exit_open", exit_open, 0);
      chk("ar_entr_gate", entrance_gate, 0);
      chk("ar_hour", hour, 0);
      chk("ar_day_done", day_done, 0);
      entry_sensor = 0;
      #1;
      reset = 0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step(1);
         seen = seen | entrance_gate | entry_open;
      end
      chk("ar_no_pulse", seen, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
